// File: rtl/cfglut_pkg.sv
// Shared types, limits and helpers for the reconfigurable K-input LUT.
package cfglut_pkg;

    localparam int unsigned K_MIN = 2;
    localparam int unsigned K_MAX = 8;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Ceiling log2 for elaboration-time width sizing; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned b = 0; b < 32; b++) begin
            if ((32'd1 << b) < v) r = b + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cfglut_k_if.sv
// Parallel truth-table reload channel.
//  LD_VLD  word valid (master -> slave)
//  LD_DATA word payload, word 0 first (master -> slave)
//  LD_RDY  word ready (slave -> master)
//  BUSY    reload in progress (slave -> master)
interface cfglut_k_if #(
    parameter int unsigned LW = 8
);
    logic          LD_VLD;
    logic          LD_RDY;
    logic [LW-1:0] LD_DATA;
    logic          BUSY;

    modport master (output LD_VLD, output LD_DATA, input LD_RDY, input BUSY);
    modport slave  (input LD_VLD, input LD_DATA, output LD_RDY, output BUSY);
endinterface

// File: rtl/cfglut_ldfsm.sv
// Reload handshake FSM and word counter.
//  i_clk, i_rst_n  clock / async active-low reset
//  i_vld           word accepted this edge (ready is always high)
//  o_busy          at least one word taken, commit still pending
//  o_wr_en_c       one-hot shadow word write strobe for this edge
//  o_commit_c      last word taken this edge: copy shadow into table
module cfglut_ldfsm
    import cfglut_pkg::*;
#(
    parameter int unsigned NW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_vld,
    output logic          o_busy,
    output logic [NW-1:0] o_wr_en_c,
    output logic          o_commit_c
);

    localparam int unsigned CW = (NW > 1) ? clog2(NW) : 1;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          w_last;

    // Counter is zero in IDLE, so it always names the word being written.
    assign w_last     = (r_cnt == CW'(NW - 1));
    assign o_wr_en_c  = i_vld ? (NW'(1) << r_cnt) : '0;
    assign o_commit_c = i_vld && w_last;
    assign o_busy     = (r_state == LOAD);

    // State and word counter; gaps in LD_VLD simply hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (i_vld) begin
            if (w_last) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= LOAD;
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cfglut_k.sv
// K-input reconfigurable LUT with serial shift and atomic parallel reload.
//  CLK, RST_N  clock / async active-low reset
//  I           select inputs; O6 = table[I], O5 = table[{0, I[K-2:0]}]
//  CE, CDI     serial shift enable / data in; CDO = table[D-1]
//  ld          parallel reload channel (LD_VLD/LD_RDY/LD_DATA/BUSY)
module cfglut_k
    import cfglut_pkg::*;
#(
    parameter int unsigned       K       = 6,
    parameter logic [(1<<K)-1:0] INIT    = '0,
    parameter int unsigned       LW      = 8,
    parameter bit                REG_OUT = 1'b0
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [K-1:0] I,
    output logic         O6,
    output logic         O5,
    input  logic         CE,
    input  logic         CDI,
    output logic         CDO,
    cfglut_k_if.slave    ld
);

    localparam int unsigned D  = 1 << K;
    localparam int unsigned NW = D / LW;

    if (K < K_MIN || K > K_MAX) begin : g_bad_k
        $error("cfglut_k: K must be in 2..8");
    end
    if (LW == 0 || (D % LW) != 0) begin : g_bad_lw
        $error("cfglut_k: LW must divide 2**K");
    end

    logic [D-1:0]  r_table;
    logic [D-1:0]  r_shadow;
    logic [D-1:0]  w_shadow_nxt;
    logic [NW-1:0] w_wr_en;
    logic          w_commit;
    logic          w_busy;
    logic          w_accept;
    logic          w_shift;
    logic          w_o6;
    logic          w_o5;

    cfglut_ldfsm #(.NW(NW)) u_ldfsm (
        .i_clk      (CLK),
        .i_rst_n    (RST_N),
        .i_vld      (ld.LD_VLD),
        .o_busy     (w_busy),
        .o_wr_en_c  (w_wr_en),
        .o_commit_c (w_commit)
    );

    assign ld.LD_RDY = 1'b1;
    assign ld.BUSY   = w_busy;
    assign w_accept  = ld.LD_VLD;
    // A reload owns the table: shifting waits until the cycle after commit.
    assign w_shift   = CE && !w_busy && !w_accept;

    // Shadow image including this edge's word, so the commit is one edge.
    for (genvar w = 0; w < NW; w++) begin : g_shadow
        assign w_shadow_nxt[w*LW +: LW] = w_wr_en[w] ? ld.LD_DATA : r_shadow[w*LW +: LW];
    end

    // Truth table and reload shadow.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_table  <= INIT;
            r_shadow <= '0;
        end else begin
            if (w_accept) r_shadow <= w_shadow_nxt;
            if (w_commit) begin
                r_table <= w_shadow_nxt;
            end else if (w_shift) begin
                r_table <= {r_table[D-2:0], CDI};
            end
        end
    end

    assign CDO  = r_table[D-1];
    assign w_o6 = r_table[I];
    assign w_o5 = r_table[{1'b0, I[K-2:0]}];

    if (REG_OUT) begin : g_reg_out
        logic r_o6;
        logic r_o5;
        // Output stage samples I against the pre-edge table.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_o6 <= 1'b0;
                r_o5 <= 1'b0;
            end else begin
                r_o6 <= w_o6;
                r_o5 <= w_o5;
            end
        end
        assign O6 = r_o6;
        assign O5 = r_o5;
    end else begin : g_comb_out
        assign O6 = w_o6;
        assign O5 = w_o5;
    end

endmodule
